qs_out_buf: RTL and testbench

- Downstream stage of the qs sort engine. Consumes its sorted output stream (vld/sop/eop/err/dat), which has no backpressure.
- Checks each packet for ascending order and for correct framing.
- Buffers words in a FIFO and re-presents them to a consumer over a valid/ready handshake.
- On overflow, terminates the packet in progress with an error, so the consumer never sees an unterminated packet.

---
 rtl/qs_out_buf.sv | 182 ++++++++++++++++++
 tb/tb_qs_out_buf.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qs_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : qs_out_buf
// Brief    : Output buffer for the qs sort engine. Checks each incoming packet
//            for framing and ascending order, stores words in a FIFO and
//            re-presents them over valid/ready. When the FIFO overflows, the
//            packet in progress is closed with an error word.
// Revision : 1.0 - initial release
// ============================================================================
module qs_out_buf #(
  parameter int OPT_W = 32,
  parameter int DEPTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_err,
  input  logic [OPT_W-1:0] in_dat,
  output logic             out_vld_r,
  output logic             out_sop_r,
  output logic             out_eop_r,
  output logic             out_err_r,
  output logic [OPT_W-1:0] out_dat_r,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] stat_pkt_cnt_r,
  output logic             stat_unsorted_r,
  output logic             stat_ovf_r,
  output logic             stat_frm_r
);

  localparam int            c_AW    = $clog2(DEPTH);
  localparam int            c_EW    = OPT_W + 3;
  localparam logic [c_AW:0] c_FULL  = (c_AW + 1)'(DEPTH);
  localparam logic [c_AW:0] c_AFULL = (c_AW + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [c_EW-1:0]  r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic [OPT_W-1:0] r_prev, w_prev_nxt;
  logic             r_pkt_err, w_pkt_err_nxt;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic             r_unsorted, r_ovf, r_frm;

  logic             w_wr_en;
  logic [c_EW-1:0]  w_wr_ent;
  logic             w_set_ovf, w_set_frm, w_set_uns;
  logic             w_start;
  logic             w_full, w_afull, w_empty, w_pop;
  logic             w_viol, w_werr;
  logic [c_EW-1:0]  w_head;

  // Write decisions use start-of-cycle occupancy; a same-cycle pop frees nothing.
  assign w_full  = (r_count == c_FULL);
  assign w_afull = (r_count == c_AFULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_rdy;
  assign w_viol  = (in_dat < r_prev);
  assign w_werr  = in_err | w_viol;

  // Packet FSM: framing/order checks and write-entry formation ({sop,eop,err,dat}).
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_en       = 1'b0;
    w_wr_ent      = '0;
    w_prev_nxt    = r_prev;
    w_pkt_err_nxt = r_pkt_err;
    w_set_ovf     = 1'b0;
    w_set_frm     = 1'b0;
    w_set_uns     = 1'b0;
    w_start       = 1'b0;
    if (in_vld) begin
      case (r_state)
        ST_IDLE: begin
          if (in_sop) w_start   = 1'b1;
          else        w_set_frm = 1'b1;
        end
        ST_PKT: begin
          if (in_sop) begin
            // Previous packet is left unterminated; the new one starts fresh.
            w_set_frm = 1'b1;
            w_start   = 1'b1;
          end else begin
            w_set_uns = w_viol;
            if (w_afull && !in_eop) begin
              w_wr_en     = 1'b1;
              w_wr_ent    = {1'b0, 1'b1, 1'b1, in_dat};
              w_set_ovf   = 1'b1;
              w_state_nxt = ST_DROP;
            end else if (w_full) begin
              w_set_ovf   = 1'b1;
              w_state_nxt = in_eop ? ST_IDLE : ST_DROP;
            end else begin
              w_wr_en       = 1'b1;
              w_wr_ent      = {1'b0, in_eop, in_eop ? (r_pkt_err | w_werr) : w_werr, in_dat};
              w_prev_nxt    = in_dat;
              w_pkt_err_nxt = r_pkt_err | w_werr;
              if (in_eop) w_state_nxt = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          w_set_frm = in_sop;
          if (in_eop) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase

      // Start of a new packet, shared by IDLE and the mid-packet sop case.
      if (w_start) begin
        if (w_full) begin
          w_set_ovf   = 1'b1;
          w_state_nxt = in_eop ? ST_IDLE : ST_DROP;
        end else if (w_afull && !in_eop) begin
          w_wr_en     = 1'b1;
          w_wr_ent    = {1'b1, 1'b1, 1'b1, in_dat};
          w_set_ovf   = 1'b1;
          w_state_nxt = ST_DROP;
        end else begin
          w_wr_en       = 1'b1;
          w_wr_ent      = {1'b1, in_eop, in_err, in_dat};
          w_prev_nxt    = in_dat;
          w_pkt_err_nxt = in_err;
          w_state_nxt   = in_eop ? ST_IDLE : ST_PKT;
        end
      end
    end
  end

  // FIFO storage; contents are qualified by r_count so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_ent;
  end

  // Control state, FIFO pointers/occupancy and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_prev     <= '0;
      r_pkt_err  <= 1'b0;
      r_pkt_cnt  <= '0;
      r_unsorted <= 1'b0;
      r_ovf      <= 1'b0;
      r_frm      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= w_prev_nxt;
      r_pkt_err <= w_pkt_err_nxt;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (c_AW + 1)'(w_wr_en) - (c_AW + 1)'(w_pop);
      if (w_wr_en && w_wr_ent[c_EW-2]) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if (w_set_uns) r_unsorted <= 1'b1;
      if (w_set_ovf) r_ovf      <= 1'b1;
      if (w_set_frm) r_frm      <= 1'b1;
    end
  end

  // Head is read straight from storage and forced to zero when empty.
  assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_vld_r = !w_empty;
  assign {out_sop_r, out_eop_r, out_err_r, out_dat_r} = w_head;

  assign stat_pkt_cnt_r  = r_pkt_cnt;
  assign stat_unsorted_r = r_unsorted;
  assign stat_ovf_r      = r_ovf;
  assign stat_frm_r      = r_frm;

endmodule
`default_nettype wire

// File: tb/tb_qs_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_qs_out_buf
// Brief    : Self-checking bench for qs_out_buf (DEPTH = 4) with a queue-based
//            reference model, directed scenarios and a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qs_out_buf;

  localparam int OPT_W = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;
  localparam int S_IDLE = 0;
  localparam int S_PKT  = 1;
  localparam int S_DROP = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld, in_sop, in_eop, in_err;
  logic [OPT_W-1:0] in_dat;
  logic             out_vld_r, out_sop_r, out_eop_r, out_err_r;
  logic [OPT_W-1:0] out_dat_r;
  logic             out_rdy;
  logic [CNT_W-1:0] stat_pkt_cnt_r;
  logic             stat_unsorted_r, stat_ovf_r, stat_frm_r;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;
  bit tog = 1'b0;

  qs_out_buf #(.OPT_W(OPT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_err(in_err), .in_dat(in_dat),
    .out_vld_r(out_vld_r), .out_sop_r(out_sop_r), .out_eop_r(out_eop_r),
    .out_err_r(out_err_r), .out_dat_r(out_dat_r), .out_rdy(out_rdy),
    .stat_pkt_cnt_r(stat_pkt_cnt_r), .stat_unsorted_r(stat_unsorted_r),
    .stat_ovf_r(stat_ovf_r), .stat_frm_r(stat_frm_r)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [34:0] mq[$];
  int          m_st;
  logic [31:0] m_prev, m_cnt;
  bit          m_perr, m_uns, m_ovf, m_frm;

  always @(posedge clk) begin : model
    int          occ;
    bit          pop, wr, start, viol, werr;
    logic [34:0] ent;
    if (rst) begin
      mq.delete();
      m_st = S_IDLE; m_prev = '0; m_perr = 0; m_cnt = '0;
      m_uns = 0; m_ovf = 0; m_frm = 0;
    end else begin
      occ = mq.size();
      pop = (occ > 0) && out_rdy;
      wr = 0; start = 0; ent = '0;
      if (in_vld) begin
        if (m_st == S_DROP) begin
          if (in_sop) m_frm = 1;
          if (in_eop) m_st = S_IDLE;
        end else if (in_sop) begin
          if (m_st == S_PKT) m_frm = 1;
          start = 1;
        end else if (m_st == S_IDLE) begin
          m_frm = 1;
        end else begin
          viol = (in_dat < m_prev);
          if (viol) m_uns = 1;
          werr = in_err | viol;
          if (occ == DEPTH) begin
            m_ovf = 1;
            m_st = in_eop ? S_IDLE : S_DROP;
          end else if (occ == DEPTH - 1 && !in_eop) begin
            ent = {1'b0, 1'b1, 1'b1, in_dat}; wr = 1; m_ovf = 1; m_st = S_DROP;
          end else begin
            m_perr = m_perr | werr;
            ent = {1'b0, in_eop, (in_eop ? m_perr : werr), in_dat};
            wr = 1; m_prev = in_dat;
            if (in_eop) m_st = S_IDLE;
          end
        end
        if (start) begin
          if (occ == DEPTH) begin
            m_ovf = 1;
            m_st = in_eop ? S_IDLE : S_DROP;
          end else if (occ == DEPTH - 1 && !in_eop) begin
            ent = {1'b1, 1'b1, 1'b1, in_dat}; wr = 1; m_ovf = 1; m_st = S_DROP;
          end else begin
            ent = {1'b1, in_eop, in_err, in_dat}; wr = 1;
            m_prev = in_dat; m_perr = in_err;
            m_st = in_eop ? S_IDLE : S_PKT;
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (wr) begin
        mq.push_back(ent);
        if (ent[33]) m_cnt = m_cnt + 1;
      end
    end
  end

  // ---------------- compare process ----------------
  logic [34:0] obs[$];
  logic [35:0] p_out;
  bit          p_vld = 0, p_rdy = 0, p_rst = 1;

  always @(negedge clk) begin : compare
    logic [35:0] act_h, exp_h;
    logic [34:0] act_s, exp_s;
    if (chk_en) begin
      act_h = {out_vld_r, out_sop_r, out_eop_r, out_err_r, out_dat_r};
      exp_h = (mq.size() > 0) ? {1'b1, mq[0]} : 36'd0;
      n_chk++;
      if (act_h !== exp_h) begin
        n_err++;
        $display("FAIL cyc_head @%0t: got %h expected %h", $time, act_h, exp_h);
      end
      act_s = {stat_pkt_cnt_r, stat_unsorted_r, stat_ovf_r, stat_frm_r};
      exp_s = {m_cnt, m_uns, m_ovf, m_frm};
      n_chk++;
      if (act_s !== exp_s) begin
        n_err++;
        $display("FAIL cyc_stat @%0t: got %h expected %h", $time, act_s, exp_s);
      end
      if (p_vld && !p_rdy && !p_rst) begin
        n_chk++;
        if (act_h !== p_out) begin
          n_err++;
          $display("FAIL hold_stable @%0t: got %h expected %h", $time, act_h, p_out);
        end
      end
      if (out_vld_r && out_rdy) obs.push_back(act_h[34:0]);
      p_out = act_h; p_vld = out_vld_r; p_rdy = out_rdy; p_rst = rst;
    end
  end

  // Alternate out_rdy every cycle while enabled.
  always @(posedge clk) begin
    if (tog) begin
      #1 out_rdy = ~out_rdy;
    end
  end

  // ---------------- helpers ----------------
  logic [34:0] exp_q[$];

  function automatic logic [34:0] mk(bit s, bit e, bit er, logic [31:0] d);
    return {s, e, er, d};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_obs(input string name);
    chk({name, "_len"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      chk($sformatf("%s_w%0d", name, i), obs[i], exp_q[i]);
    obs.delete();
    exp_q.delete();
  endtask

  task automatic send(input bit s, input bit e, input bit er, input logic [31:0] d);
    @(posedge clk); #1;
    in_vld = 1; in_sop = s; in_eop = e; in_err = er; in_dat = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_vld = 0; in_sop = 0; in_eop = 0; in_err = 0;
    end
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1;
    rst = 1; in_vld = 0; in_sop = 0; in_eop = 0; in_err = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; in_vld = 0; in_sop = 0; in_eop = 0; in_err = 0; in_dat = '0; out_rdy = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    chk("rst_vld", out_vld_r, 0);
    chk("rst_stats", {stat_pkt_cnt_r, stat_unsorted_r, stat_ovf_r, stat_frm_r}, 0);

    // Sorted packet 3,5,5,9
    out_rdy = 1; obs.delete();
    send(1, 0, 0, 3);
    chk("t1_vld_before", out_vld_r, 0);
    send(0, 0, 0, 5);
    chk("t1_vld_latency", out_vld_r, 1);
    send(0, 0, 0, 5);
    send(0, 1, 0, 9);
    idle(4);
    exp_q = '{mk(1,0,0,3), mk(0,0,0,5), mk(0,0,0,5), mk(0,1,0,9)};
    expect_obs("t1");
    chk("t1_cnt", stat_pkt_cnt_r, 1);
    chk("t1_uns", stat_unsorted_r, 0);

    // Unsorted packet 4,2,7
    send(1, 0, 0, 4); send(0, 0, 0, 2); send(0, 1, 0, 7);
    idle(4);
    exp_q = '{mk(1,0,0,4), mk(0,0,1,2), mk(0,1,1,7)};
    expect_obs("t2");
    chk("t2_uns", stat_unsorted_r, 1);
    chk("t2_cnt", stat_pkt_cnt_r, 2);

    // Overflow truncation with DEPTH = 4
    rst_pulse(); out_rdy = 0; obs.delete();
    for (int i = 1; i <= 6; i++) send(i == 1, i == 6, 0, i);
    idle(3);
    chk("t3_ovf", stat_ovf_r, 1);
    chk("t3_cnt", stat_pkt_cnt_r, 1);
    out_rdy = 1;
    idle(6);
    exp_q = '{mk(1,0,0,1), mk(0,0,0,2), mk(0,0,0,3), mk(0,1,1,4)};
    expect_obs("t3");

    // Framing errors
    rst_pulse(); out_rdy = 1; obs.delete();
    send(0, 1, 0, 7);
    idle(3);
    chk("t4_frm", stat_frm_r, 1);
    chk("t4_nothing", obs.size(), 0);
    send(1, 0, 0, 1); send(0, 0, 0, 2); send(1, 0, 0, 5); send(0, 1, 0, 6);
    idle(4);
    exp_q = '{mk(1,0,0,1), mk(0,0,0,2), mk(1,0,0,5), mk(0,1,0,6)};
    expect_obs("t4");

    // Backpressure: out_rdy toggles each cycle, 10 words 0..9
    rst_pulse(); obs.delete(); out_rdy = 1; tog = 1;
    for (int i = 0; i < 10; i++) begin
      send(i == 0, i == 9, 0, i);
      idle(1);
    end
    idle(8);
    tog = 0; #2 out_rdy = 1;
    idle(3);
    for (int i = 0; i < 10; i++) exp_q.push_back(mk(i == 0, i == 9, 0, i));
    expect_obs("t5");

    // Reset mid-packet with 3 words buffered
    rst_pulse(); out_rdy = 0;
    send(1, 0, 0, 10); send(0, 0, 0, 11); send(0, 0, 0, 12);
    rst_pulse();
    chk("t6_vld", out_vld_r, 0);
    chk("t6_stats", {stat_pkt_cnt_r, stat_unsorted_r, stat_ovf_r, stat_frm_r}, 0);
    out_rdy = 1; obs.delete();
    send(1, 0, 0, 20); send(0, 1, 0, 21);
    idle(4);
    exp_q = '{mk(1,0,0,20), mk(0,1,0,21)};
    expect_obs("t6");

    // Randomized traffic
    rst_pulse();
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst     = ($urandom_range(0, 599) == 0);
      in_vld  = ($urandom_range(0, 3) != 0);
      in_sop  = ($urandom_range(0, 5) == 0);
      in_eop  = ($urandom_range(0, 4) == 0);
      in_err  = ($urandom_range(0, 15) == 0);
      in_dat  = $urandom_range(0, 15);
      out_rdy = $urandom_range(0, 1);
    end
    @(posedge clk); #1;
    rst = 0; out_rdy = 1;
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
